// File: rtl/write_ctrl_pkg.sv
// Shared definitions for the multi-channel buffer write controller:
// FSM state encodings and a constant-friendly clog2 helper.
package write_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] WRITE = 2'b10;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches req starting one past last_grant,
// wrapping modulo CHANNELS.
module rr_arbiter
  import write_ctrl_pkg::*;
#(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned CH_WIDTH = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_WIDTH-1:0] last_grant,
  output logic                any,
  output logic [CH_WIDTH-1:0] grant
);

  logic [CH_WIDTH-1:0] cand;

  always_comb begin
    any   = 1'b0;
    grant = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      cand = CH_WIDTH'((32'(last_grant) + k) % CHANNELS);
      if (!any && req[cand]) begin
        any   = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/multi_channel_write_controller.sv
// Round-robin write-side controller for a shared circular buffer: grants one
// producer at a time, emits one write strobe per transaction and tracks occupancy.
module multi_channel_write_controller
  import write_ctrl_pkg::*;
#(
  parameter  int unsigned CHANNELS   = 4,
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_WIDTH = clog2(DEPTH),
  localparam int unsigned CH_WIDTH   = clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            w_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] w_data,
  input  logic                           rd_done,
  output logic [CHANNELS-1:0]            ready,
  output logic                           buff_w,
  output logic [ADDR_WIDTH-1:0]          buff_addr,
  output logic [DATA_WIDTH-1:0]          buff_data,
  output logic [CH_WIDTH-1:0]            buff_ch,
  output logic [ADDR_WIDTH:0]            count,
  output logic                           full,
  output logic                           empty
);

  logic [1:0]            state_q, state_d;
  logic [CH_WIDTH-1:0]   grant_q, grant_d;
  logic [CH_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  arb_any;
  logic [CH_WIDTH-1:0]   arb_grant;
  logic                  do_write, do_pop;

  rr_arbiter #(
    .CHANNELS(CHANNELS)
  ) u_arb (
    .req       (w_en),
    .last_grant(last_grant_q),
    .any       (arb_any),
    .grant     (arb_grant)
  );

  assign full  = (count_q == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    wr_ptr_d     = wr_ptr_q;
    case (state_q)
      IDLE: begin
        if (arb_any && !full) begin
          state_d = GRANT;
          grant_d = arb_grant;
        end
      end
      GRANT: begin
        // Producer drops w_en to commit; the word is taken on that same edge.
        if (!w_en[grant_q]) begin
          data_d       = w_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
          last_grant_d = grant_q;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign do_write = (state_q == WRITE);
  assign do_pop   = rd_done && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({do_write, do_pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_WIDTH'(CHANNELS - 1);
      data_q       <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == GRANT) ready[grant_q] = 1'b1;
  end

  assign buff_w    = (state_q == WRITE);
  assign buff_addr = wr_ptr_q;
  assign buff_data = data_q;
  assign buff_ch   = grant_q;
  assign count     = count_q;

endmodule

// File: tb/tb_multi_channel_write_controller.sv
// Self-checking bench: bench-driven producers plus a transaction-level model of
// grant order, write strobes and occupancy, with directed and random phases.
module tb_multi_channel_write_controller;

  localparam int CH    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    w_en;
  logic [CH*DW-1:0] w_data;
  logic             rd_done;
  logic [CH-1:0]    ready;
  logic             buff_w;
  logic [AW-1:0]    buff_addr;
  logic [DW-1:0]    buff_data;
  logic [CW-1:0]    buff_ch;
  logic [AW:0]      count;
  logic             full;
  logic             empty;

  always #5 clk = ~clk;

  multi_channel_write_controller #(
    .CHANNELS  (CH),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .w_en     (w_en),
    .w_data   (w_data),
    .rd_done  (rd_done),
    .ready    (ready),
    .buff_w   (buff_w),
    .buff_addr(buff_addr),
    .buff_data(buff_data),
    .buff_ch  (buff_ch),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  int checks   = 0;
  int failures = 0;

  // Producer behaviour
  logic [CH-1:0] want;
  bit            rearm;
  int            hold[CH];
  logic [DW-1:0] payload[CH];
  bit            rd_now;

  // Reference model: one outstanding transaction, owner = granted channel
  int            m_owner;
  bit            m_wpend;
  int            m_waddr, m_wch, m_ptr, m_count, m_last;
  logic [DW-1:0] m_wdata;

  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  logic [CW-1:0] obs_ch[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [CH-1:0] req);
    for (int k = 1; k <= CH; k++) begin
      if (req[(m_last + k) % CH]) return (m_last + k) % CH;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [CH-1:0] we,
                            input logic [CH*DW-1:0] wd, input logic rd);
    bit was_w;
    if (r) begin
      m_owner = -1; m_wpend = 0; m_ptr = 0; m_count = 0; m_last = CH - 1;
      return;
    end
    was_w = m_wpend;
    if (was_w) begin
      m_wpend = 0;
      m_ptr   = (m_ptr + 1) % DEPTH;
    end else if (m_owner >= 0) begin
      if (!we[m_owner]) begin
        m_wpend = 1;
        m_waddr = m_ptr;
        m_wch   = m_owner;
        m_wdata = wd[m_owner*DW +: DW];
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (m_count != DEPTH && we != '0) begin
      m_owner = rr_pick(we);
    end
    m_count = m_count + (was_w ? 1 : 0) - ((rd && m_count > 0) ? 1 : 0);
  endtask

  task automatic step();
    for (int i = 0; i < CH; i++) begin
      if (ready[i] === 1'b1) begin
        if (hold[i] > 0) begin
          hold[i]--;
          w_en[i] = 1'b1;
        end else begin
          w_en[i] = 1'b0;
          w_data[i*DW +: DW] = payload[i];
          payload[i] = DW'($urandom);
          if (!rearm) want[i] = 1'b0;
        end
      end else begin
        w_en[i] = want[i];
        w_data[i*DW +: DW] = DW'($urandom);
      end
    end
    rd_done = rd_now;
    @(posedge clk);
    model_edge(rst, w_en, w_data, rd_done);
    #1;
    chk("ready", 32'(ready), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("buff_w", 32'(buff_w), 32'(m_wpend));
    if (m_wpend) begin
      chk("buff_addr", 32'(buff_addr), m_waddr);
      chk("buff_data", 32'(buff_data), 32'(m_wdata));
      chk("buff_ch", 32'(buff_ch), m_wch);
    end
    chk("count", 32'(count), m_count);
    chk("full", 32'(full), 32'(m_count == DEPTH));
    chk("empty", 32'(empty), 32'(m_count == 0));
    if (buff_w === 1'b1) begin
      obs_addr.push_back(buff_addr);
      obs_data.push_back(buff_data);
      obs_ch.push_back(buff_ch);
    end
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_ch.delete();
  endtask

  task automatic do_reset();
    want = '0; rearm = 0; rd_now = 0;
    for (int i = 0; i < CH; i++) hold[i] = 0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_obs();
  endtask

  initial begin
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    w_en = '0; w_data = '0; rd_done = 1'b0; rd_now = 0; rearm = 0;
    for (int i = 0; i < CH; i++) begin
      hold[i] = 0;
      payload[i] = DW'($urandom);
    end
    m_owner = -1; m_wpend = 0; m_ptr = 0; m_count = 0; m_last = CH - 1;

    // Reset with every producer requesting
    want = '1;
    rst  = 1'b1;
    step();
    step();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_buff_w", 32'(buff_w), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_addr", 32'(buff_addr), 0);
    chk("rst_data", 32'(buff_data), 0);
    chk("rst_ch", 32'(buff_ch), 0);
    rst = 1'b0;
    step();
    chk("first_grant", 32'(ready), 32'h1);

    // Single write from channel 2
    do_reset();
    want = 4'b0100; hold[2] = 2; payload[2] = 16'hBEEF;
    for (int n = 0; n < 8; n++) step();
    chk("single_n", obs_ch.size(), 1);
    if (obs_ch.size() >= 1) begin
      chk("single_addr", 32'(obs_addr[0]), 0);
      chk("single_data", 32'(obs_data[0]), 32'hBEEF);
      chk("single_ch", 32'(obs_ch[0]), 2);
    end
    chk("single_count", 32'(count), 1);

    // Fairness with all channels continuously requesting
    do_reset();
    want = '1; rearm = 1;
    for (int n = 0; n < 40 && obs_ch.size() < 5; n++) step();
    chk("fair_n", obs_ch.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < obs_ch.size()) chk("fair_ch", 32'(obs_ch[k]), exp_seq[k]);
    end

    // Fill to full, then one pop and the wrapped write
    do_reset();
    want = '1; rearm = 1;
    for (int n = 0; n < 100 && obs_ch.size() < 16; n++) step();
    for (int n = 0; n < 5; n++) step();
    chk("full_flag", 32'(full), 1);
    chk("full_no_grant", 32'(ready), 0);
    chk("full_count", 32'(count), 16);
    rd_now = 1; step(); rd_now = 0;
    chk("pop_count", 32'(count), 15);
    for (int n = 0; n < 10 && obs_ch.size() < 17; n++) step();
    chk("wrap_n", obs_ch.size(), 17);
    if (obs_addr.size() >= 17) chk("wrap_addr", 32'(obs_addr[16]), 0);

    // Simultaneous write and pop at count 5, then pop on empty
    do_reset();
    want = '1; rearm = 1;
    for (int n = 0; n < 60 && obs_ch.size() < 6; n++) step();
    chk("sim_pre", 32'(count), 5);
    want = '0; rearm = 0;
    rd_now = 1; step(); rd_now = 0;
    chk("sim_count", 32'(count), 5);
    rd_now = 1;
    for (int n = 0; n < 5; n++) step();
    chk("drain_count", 32'(count), 0);
    step();
    rd_now = 0;
    chk("pop_empty_count", 32'(count), 0);
    chk("pop_empty_flag", 32'(empty), 1);

    // Reset while channel 1 holds the grant
    do_reset();
    want = 4'b0010; hold[1] = 50;
    for (int n = 0; n < 5 && ready[1] !== 1'b1; n++) step();
    chk("mid_grant1", 32'(ready), 32'h2);
    want[0] = 1'b1;
    rst = 1'b1; step(); rst = 1'b0;
    hold[1] = 0;
    chk("mid_rst_ready", 32'(ready), 0);
    step();
    chk("mid_next_grant", 32'(ready), 32'h1);
    chk("mid_no_write", obs_ch.size(), 0);
    chk("mid_count", 32'(count), 0);
    for (int n = 0; n < 10 && obs_ch.size() < 1; n++) step();
    if (obs_ch.size() >= 1) begin
      chk("mid_addr", 32'(obs_addr[0]), 0);
      chk("mid_ch", 32'(obs_ch[0]), 0);
    end else begin
      chk("mid_write_seen", obs_ch.size(), 1);
    end
    want = '0;
    for (int n = 0; n < 8; n++) step();

    // Random traffic with withdrawals, pops and one mid-run reset
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < CH; i++) begin
        if (!want[i] && ready[i] !== 1'b1 && $urandom_range(0, 3) == 0) begin
          want[i] = 1'b1;
          hold[i] = $urandom_range(0, 3);
        end else if (want[i] && ready[i] !== 1'b1 && $urandom_range(0, 15) == 0) begin
          want[i] = 1'b0;
        end
      end
      rd_now = ($urandom_range(0, 2) == 0);
      rst    = (n == 300);
      step();
    end
    rst = 1'b0; rd_now = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_channel_write_controller.md
# multi_channel_write_controller

- Parametrised write-side controller in front of the shared circular buffer.
- Arbitrates round-robin among CHANNELS producers using the level w_en/ready write handshake.
- Captures the winning producer's data, issues one buffer write strobe per transaction with address, data and channel tag, and advances the write pointer with wrap-around.
- Tracks buffer occupancy against reader pops and derives full/empty itself, so producers no longer need an external full signal.

## Interface
Parameters:
- CHANNELS, 4, number of producer channels (≥2)
- DATA_WIDTH, 16, width of one buffer word
- DEPTH, 16, buffer entries; power of two, ≥2
- ADDR_WIDTH, clog2(DEPTH), derived; not overridden
- CH_WIDTH, clog2(CHANNELS), derived; not overridden

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- w_en  in  CHANNELS  per-channel write request, held high until ready is seen
- w_data  in  CHANNELS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- rd_done  in  1  reader consumed one entry this cycle
- ready  out  CHANNELS  one-hot grant; at most one bit high
- buff_w  out  1  buffer write strobe, one cycle
- buff_addr  out  ADDR_WIDTH  write address, valid with buff_w
- buff_data  out  DATA_WIDTH  write data, valid with buff_w
- buff_ch  out  CH_WIDTH  source channel, valid with buff_w
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- FSM states: IDLE, GRANT, WRITE. Outputs are Moore, decoded from registered state, grant index and data register.
- **IDLE:** if any w_en is high and !full, choose the channel by round-robin and go to GRANT. Otherwise stay in IDLE.
  - Round-robin search starts at last_grant+1 and wraps modulo CHANNELS.
  - After reset last_grant = CHANNELS-1, so channel 0 has first priority.
- **GRANT:** ready[g]=1.
  - w_en[g] high: stay in GRANT.
  - w_en[g] low: capture w_data[g] on that edge, set last_grant=g, go to WRITE.
  - Other channels' w_en are ignored while in GRANT.
- **WRITE:** buff_w=1, buff_addr=wr_ptr, buff_data=captured word, buff_ch=g. On the edge: wr_ptr increments, wrapping DEPTH-1 -> 0, and the FSM goes to IDLE.
- **Occupancy:**
  - +1 on the WRITE edge; -1 on rd_done when count>0.
  - rd_done with count==0 is ignored.
  - Write and rd_done on the same edge leave count unchanged.
- full is checked only in IDLE. It cannot rise during GRANT, because only this block writes.
- A producer that drops w_en without ever having been granted loses nothing: there is no commit and no state change.

## Timing
- Reset values: state=IDLE, ready=0, buff_w=0, buff_addr=0, buff_data=0, buff_ch=0, count=0, full=0, empty=1, wr_ptr=0.
- Reset asserted mid-transaction aborts it: no buff_w, and the captured data is discarded.
- Handshake, with edges counted from edge E0, where w_en is sampled high in IDLE:
  - ready goes high after E0.
  - If w_en is sampled low at edge E1, buff_w is high for the E1–E2 cycle.
  - The FSM is back in IDLE after E2. Minimum 3 cycles per write.
- Earliest next grant: ready after E3. Back-to-back writes are therefore one per 3 cycles.
- count, full and empty update on the same edge that ends the WRITE cycle, or the edge that samples rd_done.

## Structure
- Package write_ctrl_pkg holds:
  - state encodings IDLE=2'b00, GRANT=2'b01, WRITE=2'b10;
  - the clog2 helper function.
- Sub-module rr_arbiter (parameter CHANNELS):
  - inputs req and last_grant;
  - outputs any and grant index;
  - purely combinational.
- Remaining registers live in the top module: FSM, grant index, data capture, wr_ptr, count.

## Test plan
- Reset/idle: hold rst 2 cycles with all w_en=1 -> ready=0, buff_w=0, count=0, empty=1.
  - Release -> ready=4'b0001 one cycle later.
- Single write: ch2 w_en high 3 cycles, then low with w_data=16'hBEEF -> exactly one buff_w pulse with addr=0, data=BEEF, ch=2; count=1.
- Fairness: all four w_en always high, each dropping for one cycle after its grant -> buff_ch sequence 0,1,2,3,0.
- Full/wrap: 16 writes with no rd_done -> full=1 and further w_en is not granted.
  - One rd_done -> count=15; the next write goes to addr=0.
- Simultaneous: rd_done asserted in the WRITE cycle at count=5 -> count stays 5.
  - rd_done at count=0 -> count stays 0.
- Reset mid-GRANT: rst pulsed while ready[1]=1 -> no buff_w, count unchanged at 0, wr_ptr=0, next grant to ch0.
